// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: signal bundle between the interrupt controller and its
// environment (request sources plus the CPU side).
//   irq_in      raw request lines, rising edge requests service
//   irq_mask    1 = line enabled
//   irq_ack     one-cycle end-of-ISR strobe
//   interrupt   one-cycle pulse towards the CPU
//   irq_id      index of the last granted line
//   irq_busy    high from grant until ack accepted
//   irq_pending current pending register
// Modports: master = request/CPU side, slave = controller.
interface irq_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             irq_ack;
  logic             interrupt;
  logic [ID_W-1:0]  irq_id;
  logic             irq_busy;
  logic [N_IRQ-1:0] irq_pending;

  modport master (
    output irq_in, irq_mask, irq_ack,
    input  interrupt, irq_id, irq_busy, irq_pending
  );

  modport slave (
    input  irq_in, irq_mask, irq_ack,
    output interrupt, irq_id, irq_busy, irq_pending
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller feeding the single interrupt input of
// VerySimpleCPU. Rising edges on irq_in are latched as pending, masked, and
// one winner is granted per service sequence. A grant produces a one-cycle
// interrupt pulse, then further grants are held off until irq_ack.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  irq_ctrl_if.slave (irq_in, irq_mask, irq_ack in;
//        interrupt, irq_id, irq_busy, irq_pending out)
// Build option: IRQ_CTRL_ROTATE_EN selects round-robin priority; when not
// defined, the lowest eligible index wins and no pointer exists.
module irq_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input logic        clk,
  input logic        rst,
  irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic             grant;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  id_q;

  assign edge_det = bus.irq_in & ~irq_q;
  assign eligible = pending & bus.irq_mask;
  assign grant    = (state == IDLE) && (|eligible);

`ifdef IRQ_CTRL_ROTATE_EN
  logic [ID_W-1:0]    ptr;
  logic [2*N_IRQ-1:0] rot;

  // Rotating the doubled vector right by ptr puts index ptr at bit 0, so the
  // lowest set bit of the low half is the first eligible line at/after ptr.
  always_comb begin
    int unsigned tmp;
    tmp    = 0;
    rot    = {eligible, eligible} >> ptr;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        tmp   = 32'(ptr) + i;
        if (tmp >= 32'(N_IRQ)) tmp = tmp - 32'(N_IRQ);
        winner = ID_W'(tmp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (grant)
      ptr <= (winner == ID_W'(N_IRQ - 1)) ? '0 : winner + 1'b1;
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (!found && eligible[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    clr = '0;
    if (grant) clr[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = PULSE;
      PULSE:   state_nxt = bus.irq_ack ? IDLE : SERVICE;
      SERVICE: if (bus.irq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // irq_q also loads during reset so a line already high at release is not
  // seen as an edge. Set wins over clear in the pending update.
  always_ff @(posedge clk) begin
    irq_q <= bus.irq_in;
    if (!rst) begin
      state   <= IDLE;
      pending <= '0;
      id_q    <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr) | edge_det;
      if (grant) id_q <= winner;
    end
  end

  assign bus.interrupt   = (state == PULSE);
  assign bus.irq_busy    = (state != IDLE);
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pending;

endmodule
